pipeline_share_arbiter: RTL and testbench

PIPELINE_SHARE_ARBITER -- requirements
Module: pipeline_share_arbiter

---
 rtl/pipeline_share_arbiter.sv | 166 ++++++++++++++++
 tb/tb_pipeline_share_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_share_arbiter.sv
// pipeline_share_arbiter
// Shares one PSTAGE-deep pipeline among N_REQ requesters. Each cycle at most one
// requester is granted by round-robin. Every stage advances together under one
// clock enable (ce). A flush request stops new grants, waits for the pipeline to
// empty, and then pulses flush_done for one cycle.
// Optional feature: define PIPELINE_SHARE_ARBITER_PRIO0_EN to give requester 0
// strict priority. Requesters 1..N_REQ-1 then round-robin among themselves.
module pipeline_share_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int N_REQ      = 4,
    parameter int PSTAGE     = 3
) (
    input  logic                          clk,
    input  logic                          arst_n,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [N_REQ-1:0]              req_ready,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [$clog2(N_REQ)-1:0]      out_tag,
    input  logic                          out_ready,
    input  logic                          flush,
    output logic                          flush_done,
    output logic [$clog2(PSTAGE+1)-1:0]   occupancy
);

    localparam int TAG_W = $clog2(N_REQ);
    localparam int OCC_W = $clog2(PSTAGE+1);
    localparam logic [TAG_W-1:0] LAST_REQ = TAG_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] stg_data [PSTAGE];
    logic [TAG_W-1:0]      stg_tag  [PSTAGE];
    logic [PSTAGE-1:0]     stg_valid;
    logic [TAG_W-1:0]      ptr;

    logic                  ce;
    logic                  grant_any;
    logic [TAG_W-1:0]      grant_idx;
    logic [DATA_WIDTH-1:0] grant_data;
    int unsigned           rr_idx;
    logic [TAG_W-1:0]      rr_cand;

    assign out_valid = stg_valid[PSTAGE-1];
    assign out_data  = stg_data[PSTAGE-1];
    assign out_tag   = stg_tag[PSTAGE-1];
    assign ce        = out_ready | ~out_valid;

    // Grant selection: search ptr, ptr+1, ... (mod N_REQ) for the first valid requester.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        rr_idx    = 0;
        rr_cand   = '0;
        if (arst_n && ce && state == ST_RUN && !flush) begin
`ifdef PIPELINE_SHARE_ARBITER_PRIO0_EN
            if (req_valid[0]) begin
                grant_any = 1'b1;
                grant_idx = '0;
            end
`endif
            for (int unsigned k = 0; k < N_REQ; k++) begin
                rr_idx = 32'(ptr) + k;
                if (rr_idx >= N_REQ) begin
                    rr_idx = rr_idx - N_REQ;
                end
                rr_cand = TAG_W'(rr_idx);
`ifdef PIPELINE_SHARE_ARBITER_PRIO0_EN
                if (!grant_any && rr_cand != '0 && req_valid[rr_cand]) begin
`else
                if (!grant_any && req_valid[rr_cand]) begin
`endif
                    grant_any = 1'b1;
                    grant_idx = rr_cand;
                end
            end
        end
    end

    // One-hot grant vector and the granted requester's data word.
    always_comb begin
        req_ready  = '0;
        grant_data = '0;
        if (grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_idx == TAG_W'(i)) begin
                grant_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Shared pipeline stages and occupancy. All of them advance together on ce.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stg_valid <= '0;
            occupancy <= '0;
            for (int unsigned s = 0; s < PSTAGE; s++) begin
                stg_data[s] <= '0;
                stg_tag[s]  <= '0;
            end
        end else if (ce) begin
            stg_valid[0] <= grant_any;
            stg_data[0]  <= grant_data;
            stg_tag[0]   <= grant_idx;
            for (int unsigned s = 1; s < PSTAGE; s++) begin
                stg_valid[s] <= stg_valid[s-1];
                stg_data[s]  <= stg_data[s-1];
                stg_tag[s]   <= stg_tag[s-1];
            end
            // A word can leave and another can enter on the same edge, so the count stays put.
            occupancy <= occupancy + OCC_W'(grant_any) - OCC_W'(out_valid);
        end
    end

    // Round-robin pointer: it moves to the requester after the one just granted.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ptr <= '0;
`ifdef PIPELINE_SHARE_ARBITER_PRIO0_EN
        end else if (grant_any && grant_idx != '0) begin
`else
        end else if (grant_any) begin
`endif
            ptr <= (grant_idx == LAST_REQ) ? '0 : grant_idx + 1'b1;
        end
    end

    // Flush state machine. flush_done is a registered copy of the DONE state.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state      <= ST_RUN;
            flush_done <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (flush) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (occupancy == '0) begin
                        state      <= ST_DONE;
                        flush_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state      <= ST_RUN;
                    flush_done <= 1'b0;
                end
                default: begin
                    state      <= ST_RUN;
                    flush_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_share_arbiter.sv
// Testbench for pipeline_share_arbiter (DATA_WIDTH=32, N_REQ=4, PSTAGE=3).
// It applies directed vector tables, hand-written corner sequences and random
// stimulus. The random stimulus is checked against a queue-based latency model.
module tb_pipeline_share_arbiter;

    localparam int DW = 32;
    localparam int NR = 4;
    localparam int PS = 3;
    localparam int TW = $clog2(NR);
    localparam int OW = $clog2(PS+1);

    logic              clk = 1'b0;
    logic              arst_n = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*DW-1:0]  req_data = '0;
    logic [NR-1:0]     req_ready;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic [TW-1:0]     out_tag;
    logic              out_ready = 1'b1;
    logic              flush = 1'b0;
    logic              flush_done;
    logic [OW-1:0]     occupancy;

    int vectors = 0;
    int miscompares = 0;

    pipeline_share_arbiter #(
        .DATA_WIDTH(DW),
        .N_REQ(NR),
        .PSTAGE(PS)
    ) dut (
        .clk(clk),
        .arst_n(arst_n),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ready(req_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_tag(out_tag),
        .out_ready(out_ready),
        .flush(flush),
        .flush_done(flush_done),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] word_for(input int t);
        return 32'hC0DE_0000 | (t * 32'h1111);
    endfunction

    // Hold the reset for two cycles with all requesters offering, check the reset
    // state, then release the reset on a falling edge.
    task automatic do_reset();
        arst_n    = 1'b0;
        req_valid = '1;
        flush     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        #2;
        check("rst_req_ready", req_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_flush_done", flush_done, 0);
        @(negedge clk);
        arst_n    = 1'b1;
        req_valid = '0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [NR-1:0] rv;
        logic          ordy;
        logic          fl;
        logic [NR-1:0] rdy;
        logic          ov;
        int            tag;
        int            occ;
        logic          fd;
    } vec_t;

    vec_t tbl[$];

    task automatic add_vec(input logic [NR-1:0] rv, input logic ordy, input logic fl,
                           input logic [NR-1:0] rdy, input logic ov, input int tag,
                           input int occ, input logic fd);
        vec_t v;
        v.rv = rv; v.ordy = ordy; v.fl = fl; v.rdy = rdy;
        v.ov = ov; v.tag = tag; v.occ = occ; v.fd = fd;
        tbl.push_back(v);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [DW-1:0] d;
        int            tag;
        int            age;
    } ent_t;

    ent_t q[$];
    int   m_ptr;
    int   m_mode;   // 0 run, 1 draining, 2 drain finished

    function automatic int pick(input logic [NR-1:0] rv, input int p);
        int i;
`ifdef PIPELINE_SHARE_ARBITER_PRIO0_EN
        if (rv[0]) return 0;
        for (int k = 0; k < NR; k++) begin
            i = (p + k) % NR;
            if (i != 0 && rv[i]) return i;
        end
`else
        for (int k = 0; k < NR; k++) begin
            i = (p + k) % NR;
            if (rv[i]) return i;
        end
`endif
        return -1;
    endfunction

    initial begin
        logic exp_ov;
        logic ce;
        int   g;

        // ---- main vector table: round-robin, flush/drain, stall ----
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = word_for(i);
`ifndef PIPELINE_SHARE_ARBITER_PRIO0_EN
        add_vec(4'hF,1,0, 4'h1,0,0,0,0);
        add_vec(4'hF,1,0, 4'h2,0,0,1,0);
        add_vec(4'hF,1,0, 4'h4,0,0,2,0);
        add_vec(4'hF,1,0, 4'h8,1,0,3,0);
        add_vec(4'hF,1,0, 4'h1,1,1,3,0);
        add_vec(4'hF,1,0, 4'h2,1,2,3,0);
        add_vec(4'hF,1,0, 4'h4,1,3,3,0);
        add_vec(4'hF,1,0, 4'h8,1,0,3,0);
        add_vec(4'hF,1,1, 4'h0,1,1,3,0);   // flush blocks the grant
        add_vec(4'hF,1,0, 4'h0,1,2,2,0);
        add_vec(4'hF,1,0, 4'h0,1,3,1,0);
        add_vec(4'hF,1,1, 4'h0,0,0,0,0);   // flush ignored while draining
        add_vec(4'hF,1,1, 4'h0,0,0,0,1);   // done pulse, flush ignored
        add_vec(4'hF,1,0, 4'h1,0,0,0,0);   // grants resume
        add_vec(4'hF,1,0, 4'h2,0,0,1,0);
        add_vec(4'hF,1,0, 4'h4,0,0,2,0);
        for (int s = 0; s < 5; s++) add_vec(4'hF,0,0, 4'h0,1,0,3,0);  // stall
        add_vec(4'hF,1,0, 4'h8,1,0,3,0);
        add_vec(4'hF,1,0, 4'h1,1,1,3,0);
        add_vec(4'hF,1,0, 4'h2,1,2,3,0);
        add_vec(4'hF,1,0, 4'h4,1,3,3,0);
`else
        add_vec(4'hF,1,0, 4'h1,0,0,0,0);
        add_vec(4'hF,1,0, 4'h1,0,0,1,0);
        add_vec(4'hF,1,0, 4'h1,0,0,2,0);
        add_vec(4'hF,1,0, 4'h1,1,0,3,0);
        add_vec(4'hE,1,0, 4'h2,1,0,3,0);
        add_vec(4'hE,1,0, 4'h4,1,0,3,0);
        add_vec(4'hE,1,0, 4'h8,1,0,3,0);
        add_vec(4'hE,1,0, 4'h2,1,1,3,0);
`endif
        do_reset();
        foreach (tbl[r]) begin
            req_valid = tbl[r].rv;
            out_ready = tbl[r].ordy;
            flush     = tbl[r].fl;
            #2;
            check($sformatf("tbl%0d_req_ready", r), req_ready, tbl[r].rdy);
            check($sformatf("tbl%0d_out_valid", r), out_valid, tbl[r].ov);
            check($sformatf("tbl%0d_occupancy", r), occupancy, tbl[r].occ);
            check($sformatf("tbl%0d_flush_done", r), flush_done, tbl[r].fd);
            if (tbl[r].ov) begin
                check($sformatf("tbl%0d_out_tag", r), out_tag, tbl[r].tag);
                check($sformatf("tbl%0d_out_data", r), out_data, word_for(tbl[r].tag));
            end
            @(negedge clk);
        end

        // ---- single requester 2 for four cycles, then the pointer must sit at 3 ----
        do_reset();
        req_valid = 4'b0100;
        for (int c = 0; c < 4; c++) begin
            #2;
            check($sformatf("solo2_grant%0d", c), req_ready, 4'b0100);
            @(negedge clk);
        end
        req_valid = 4'b1110;
        #2;
        check("solo2_ptr_after", req_ready, 4'b1000);
        @(negedge clk);

        // ---- asynchronous reset while draining with two words in flight ----
        do_reset();
        req_valid = 4'hF;
        repeat (3) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #2;
        check("rstdrain_occ_before", occupancy, 2);
        check("rstdrain_ov_before", out_valid, 1);
        check("rstdrain_rdy_before", req_ready, 0);
        #1;
        arst_n = 1'b0;
        #1;
        check("rstdrain_ov_now", out_valid, 0);
        check("rstdrain_occ_now", occupancy, 0);
        check("rstdrain_fd_now", flush_done, 0);
        @(negedge clk);
        arst_n    = 1'b1;
        req_valid = 4'b0001;
        #2;
        check("rstdrain_run_grant", req_ready, 4'b0001);
        @(negedge clk);
        req_valid = '0;
        for (int c = 0; c < 5; c++) begin
            #2;
            check($sformatf("rstdrain_fd%0d", c), flush_done, 0);
            @(negedge clk);
        end

        // ---- random stimulus against the reference model ----
        do_reset();
        q.delete();
        m_ptr  = 0;
        m_mode = 0;
        for (int c = 0; c < 2000; c++) begin
            req_valid = NR'($urandom);
            for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            #2;
            exp_ov = (q.size() > 0) && (q[0].age == PS - 1);
            ce     = out_ready || !exp_ov;
            g      = (ce && m_mode == 0 && !flush) ? pick(req_valid, m_ptr) : -1;
            check("rnd_req_ready", req_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
            check("rnd_out_valid", out_valid, exp_ov);
            check("rnd_occupancy", occupancy, q.size());
            check("rnd_flush_done", flush_done, m_mode == 2);
            if (exp_ov) begin
                check("rnd_out_data", out_data, q[0].d);
                check("rnd_out_tag", out_tag, q[0].tag);
            end
            // advance the model across the rising edge
            if (m_mode == 0 && flush) m_mode = 1;
            else if (m_mode == 1 && q.size() == 0) m_mode = 2;
            else if (m_mode == 2) m_mode = 0;
            if (ce) begin
                if (exp_ov) void'(q.pop_front());
                foreach (q[j]) q[j].age++;
                if (g >= 0) begin
                    ent_t e;
                    e.d = req_data[g*DW +: DW];
                    e.tag = g;
                    e.age = 0;
                    q.push_back(e);
                end
            end
`ifdef PIPELINE_SHARE_ARBITER_PRIO0_EN
            if (g > 0) m_ptr = (g + 1) % NR;
`else
            if (g >= 0) m_ptr = (g + 1) % NR;
`endif
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
